// File: rtl/bp_me_lce_req_watchdog.sv
// bp_me_lce_req_watchdog
//
// Liveness monitor for one LCE's LCE-CCE interface. Every request accepted by
// the network pushes the current free-running timestamp into an in-order FIFO.
// Every completion-type command consumed by the LCE pops the head. The age of
// the head is compared against timeout_cycles_p. Timeout, overflow and
// underflow are sticky and registered. Once any fault is flagged the monitor
// sits in ERROR until clear_i.
//
// Optional feature: define BP_ME_LCE_REQ_WATCHDOG_ASSERT_EN to get a
// simulation-only $error on each rising edge of a fault flag. The hardware is
// the same with or without it.
//
// Ports:
//   clk_i                 clock
//   reset_i               asynchronous active-high reset
//   lce_req_v_i           request valid
//   lce_req_ready_then_i  request ready (handshake = v & ready)
//   lce_cmd_v_i           command-to-LCE valid
//   lce_cmd_yumi_i        command consumed (handshake = v & yumi)
//   lce_cmd_msg_type_i    msg_type of the command on the bus
//   clear_i               synchronous clear of flags, count and FIFO
//   outstanding_o         outstanding request count
//   oldest_age_o          age of the FIFO head, 0 when empty
//   timeout_o             sticky timeout flag
//   overflow_o            sticky overflow flag
//   underflow_o           sticky underflow flag
//   error_o               high while in ERROR
module bp_me_lce_req_watchdog #(
    parameter int max_outstanding_p    = 2,
    parameter int timeout_cycles_p     = 4096,
    parameter int cmd_msg_type_width_p = 4,
    parameter logic [(1 << cmd_msg_type_width_p)-1:0] cmd_done_mask_p = '0,
    localparam int ts_width_lp  = $clog2(timeout_cycles_p + 1) + 1,
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            lce_req_v_i,
    input  logic                            lce_req_ready_then_i,
    input  logic                            lce_cmd_v_i,
    input  logic                            lce_cmd_yumi_i,
    input  logic [cmd_msg_type_width_p-1:0] lce_cmd_msg_type_i,
    input  logic                            clear_i,
    output logic [cnt_width_lp-1:0]         outstanding_o,
    output logic [ts_width_lp-1:0]          oldest_age_o,
    output logic                            timeout_o,
    output logic                            overflow_o,
    output logic                            underflow_o,
    output logic                            error_o
);

    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [cnt_width_lp-1:0] max_cnt_lp  = cnt_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);
    localparam logic [ts_width_lp-1:0]  timeout_lp  = ts_width_lp'(timeout_cycles_p);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ERROR = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ts_width_lp-1:0]  now_q;
    logic [ts_width_lp-1:0]  mem_q [max_outstanding_p];
    logic [ptr_width_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [ts_width_lp-1:0]  age_q, age_d;
    logic                    timeout_q, timeout_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    error_q, error_d;

    logic                    req_fire, done_fire, is_empty, is_full, push, pop;
    logic [ts_width_lp-1:0]  age_now, head_d;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        req_fire  = lce_req_v_i & lce_req_ready_then_i;
        done_fire = lce_cmd_v_i & lce_cmd_yumi_i & cmd_done_mask_p[lce_cmd_msg_type_i];
        is_empty  = (count_q == '0);
        is_full   = (count_q == max_cnt_lp);
        age_now   = now_q - mem_q[rptr_q];

        // A full FIFO still accepts a push when the head retires on the same edge.
        pop  = done_fire & ~is_empty;
        push = req_fire & (~is_full | done_fire);

        count_d = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;

        // The new head is the entry being written this edge when the read
        // pointer lands on the write slot (empty push, or push+pop at depth 1).
        head_d = (push && (rptr_d == wptr_q)) ? now_q : mem_q[rptr_d];
        age_d  = (count_d != '0) ? (now_q - head_d) : '0;

        timeout_d   = timeout_q | (~is_empty & (age_now >= timeout_lp) & (state_q != S_ERROR));
        overflow_d  = overflow_q | (req_fire & ~done_fire & is_full);
        underflow_d = underflow_q | (done_fire & is_empty);

        if (timeout_d | overflow_d | underflow_d) begin
            state_d = S_ERROR;
        end else if (count_d != '0) begin
            state_d = S_BUSY;
        end else begin
            state_d = S_IDLE;
        end

        // Clear wins over every same-cycle handshake.
        if (clear_i) begin
            count_d     = '0;
            rptr_d      = '0;
            wptr_d      = '0;
            age_d       = '0;
            timeout_d   = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            state_d     = S_IDLE;
        end

        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            now_q       <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            age_q       <= '0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            now_q       <= now_q + 1'b1;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            age_q       <= age_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            error_q     <= error_d;
        end
    end

    // Timestamp storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wptr_q] <= now_q;
        end
    end

    assign outstanding_o = count_q;
    assign oldest_age_o  = age_q;
    assign timeout_o     = timeout_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
    assign error_o       = error_q;

`ifdef BP_ME_LCE_REQ_WATCHDOG_ASSERT_EN
`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (timeout_d && !timeout_q)
                $error("lce_req_watchdog: timeout, outstanding=%0d oldest_age=%0d", count_q, age_now);
            if (overflow_d && !overflow_q)
                $error("lce_req_watchdog: overflow, outstanding=%0d oldest_age=%0d", count_q, age_now);
            if (underflow_d && !underflow_q)
                $error("lce_req_watchdog: underflow, outstanding=%0d oldest_age=%0d", count_q, age_now);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_bp_me_lce_req_watchdog.sv
module tb_bp_me_lce_req_watchdog;

    localparam int MAX     = 2;
    localparam int TO      = 16;
    localparam int TW      = 4;
    localparam logic [15:0] MASK = 16'h0022;   // msg_types 1 and 5 retire
    localparam int TS_W    = $clog2(TO + 1) + 1;
    localparam int CNT_W   = $clog2(MAX + 1);
    localparam int AGE_MOD = 1 << TS_W;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             lce_req_v_i = 1'b0;
    logic             lce_req_ready_then_i = 1'b0;
    logic             lce_cmd_v_i = 1'b0;
    logic             lce_cmd_yumi_i = 1'b0;
    logic [TW-1:0]    lce_cmd_msg_type_i = '0;
    logic             clear_i = 1'b0;
    logic [CNT_W-1:0] outstanding_o;
    logic [TS_W-1:0]  oldest_age_o;
    logic             timeout_o, overflow_o, underflow_o, error_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of absolute acceptance cycles.
    int cyc;
    int q[$];
    bit m_to, m_ov, m_un, m_err;
    int m_age;

    bp_me_lce_req_watchdog #(
        .max_outstanding_p   (MAX),
        .timeout_cycles_p    (TO),
        .cmd_msg_type_width_p(TW),
        .cmd_done_mask_p     (MASK)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .lce_req_v_i         (lce_req_v_i),
        .lce_req_ready_then_i(lce_req_ready_then_i),
        .lce_cmd_v_i         (lce_cmd_v_i),
        .lce_cmd_yumi_i      (lce_cmd_yumi_i),
        .lce_cmd_msg_type_i  (lce_cmd_msg_type_i),
        .clear_i             (clear_i),
        .outstanding_o       (outstanding_o),
        .oldest_age_o        (oldest_age_o),
        .timeout_o           (timeout_o),
        .overflow_o          (overflow_o),
        .underflow_o         (underflow_o),
        .error_o             (error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc   = 0;
        m_to  = 0;
        m_ov  = 0;
        m_un  = 0;
        m_err = 0;
        m_age = 0;
    endtask

    task automatic model_edge(input bit req, input bit done, input bit clr);
        int n;
        if (clr) begin
            q.delete();
            m_to = 0; m_ov = 0; m_un = 0; m_err = 0; m_age = 0;
        end else begin
            n = q.size();
            if (n > 0 && !m_err && (cyc - q[0]) >= TO) m_to = 1;
            if (done && n == 0) m_un = 1;
            if (req && !done && n == MAX) m_ov = 1;
            if (done && n > 0) void'(q.pop_front());
            if (req && !(n == MAX && !done)) q.push_back(cyc);
            m_err = m_to | m_ov | m_un;
            m_age = (q.size() > 0) ? ((cyc - q[0]) % AGE_MOD) : 0;
        end
        cyc++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".outstanding"}, 32'(outstanding_o), 32'(q.size()));
        check({tag, ".age"},         32'(oldest_age_o),  32'(m_age));
        check({tag, ".timeout"},     32'(timeout_o),     32'(m_to));
        check({tag, ".overflow"},    32'(overflow_o),    32'(m_ov));
        check({tag, ".underflow"},   32'(underflow_o),   32'(m_un));
        check({tag, ".error"},       32'(error_o),       32'(m_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".outstanding"}, 32'(outstanding_o), 0);
        check({tag, ".age"},         32'(oldest_age_o),  0);
        check({tag, ".timeout"},     32'(timeout_o),     0);
        check({tag, ".overflow"},    32'(overflow_o),    0);
        check({tag, ".underflow"},   32'(underflow_o),   0);
        check({tag, ".error"},       32'(error_o),       0);
    endtask

    task automatic step(input bit v, input bit rdy, input bit cv, input bit yumi,
                        input logic [TW-1:0] ty, input bit clr, input string tag);
        lce_req_v_i          = v;
        lce_req_ready_then_i = rdy;
        lce_cmd_v_i          = cv;
        lce_cmd_yumi_i       = yumi;
        lce_cmd_msg_type_i   = ty;
        clear_i              = clr;
        @(posedge clk_i);
        model_edge(v & rdy, cv & yumi & MASK[ty], clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, '0, 0, tag);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
        check_zero("reset");
    endtask

    bit             r_clr;
    logic [TW-1:0]  r_ty;

    initial begin
        model_reset();
        lce_req_v_i = 0;
        do_reset();

        // Basic: req at cycle 0, done at cycle 5.
        step(1, 1, 0, 0, '0, 0, "basic_req");
        for (int i = 1; i < 5; i++) idle("basic_wait");
        check("basic_age_c5", 32'(oldest_age_o), 4);
        check("basic_out_c5", 32'(outstanding_o), 1);
        step(0, 0, 1, 1, 4'd1, 0, "basic_done");
        check("basic_out_c6", 32'(outstanding_o), 0);
        check("basic_err_c6", 32'(error_o), 0);

        // Timeout: req at cycle 0, never retired.
        do_reset();
        step(1, 1, 0, 0, '0, 0, "to_req");
        for (int i = 1; i < 16; i++) idle("to_wait");
        check("to_c16_timeout", 32'(timeout_o), 0);
        idle("to_wait");
        check("to_c17_timeout", 32'(timeout_o), 1);
        check("to_c17_error", 32'(error_o), 1);
        for (int i = 17; i < 20; i++) idle("to_hold");
        step(1, 1, 1, 1, 4'd1, 1, "to_clear");
        check_zero("to_c21");

        // Overflow: three reqs into a depth-2 tracker.
        step(1, 1, 0, 0, '0, 0, "ovf_req0");
        step(1, 1, 0, 0, '0, 0, "ovf_req1");
        step(1, 1, 0, 0, '0, 0, "ovf_req2");
        check("ovf_out", 32'(outstanding_o), 2);
        check("ovf_flag", 32'(overflow_o), 1);
        step(0, 0, 0, 0, '0, 1, "ovf_clear");

        // Underflow with a simultaneous request.
        step(1, 1, 1, 1, 4'd5, 0, "unf_both");
        check("unf_flag", 32'(underflow_o), 1);
        check("unf_out", 32'(outstanding_o), 1);
        step(0, 0, 0, 0, '0, 1, "unf_clear");

        // Non-completion filter.
        step(1, 1, 0, 0, '0, 0, "flt_req");
        step(0, 0, 1, 1, 4'd2, 0, "flt_nondone");
        check("flt_nondone_out", 32'(outstanding_o), 1);
        step(0, 0, 1, 0, 4'd1, 0, "flt_noyumi");
        check("flt_noyumi_out", 32'(outstanding_o), 1);
        step(0, 0, 0, 0, '0, 1, "flt_clear");

        // Wrap: req/done pairs every 10 cycles across several wraps of now.
        for (int p = 0; p < 20; p++) begin
            for (int j = 0; j < 10; j++) begin
                if (j == 0)      step(1, 1, 0, 0, '0, 0, "wrap_req");
                else if (j == 5) step(0, 0, 1, 1, 4'd1, 0, "wrap_done");
                else             idle("wrap_idle");
            end
        end
        check("wrap_timeout", 32'(timeout_o), 0);

        // Asynchronous reset mid-cycle with two requests outstanding.
        step(1, 1, 0, 0, '0, 0, "ar_req0");
        step(1, 1, 0, 0, '0, 0, "ar_req1");
        check("ar_out_before", 32'(outstanding_o), 2);
        #3;
        reset_i = 1'b1;
        #1;
        check_zero("ar_async");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
        check_all("ar_released");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            r_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1)
                r_ty = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'd5;
            else
                r_ty = 4'($urandom_range(0, 15));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 r_ty, r_clr, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
